// File: rtl/cgra_array_sched_pkg.sv
// Shared constants and FSM encoding for the CGRA array sequencer and PE instruction memories.
package cgra_array_sched_pkg;

   localparam int unsigned INST_AWIDTH_DEF  = 10;
   localparam int unsigned ITER_WIDTH_DEF   = 16;
   localparam int unsigned DRAIN_CYCLES_DEF = 4;
   localparam int unsigned CWIDTH_DEF       = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Counter width able to hold 0..n-1, never narrower than one bit
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/cgra_array_sched_if.sv
// Host-side control/status bundle of the array sequencer.
interface cgra_array_sched_if #(
   parameter int unsigned INST_AWIDTH = cgra_array_sched_pkg::INST_AWIDTH_DEF,
   parameter int unsigned ITER_WIDTH  = cgra_array_sched_pkg::ITER_WIDTH_DEF,
   parameter int unsigned CWIDTH      = cgra_array_sched_pkg::CWIDTH_DEF
);
   logic                   start;
   logic                   abort;
   logic                   stall;
   logic [INST_AWIDTH:0]   inst_num;
   logic [ITER_WIDTH-1:0]  iter_num;
   logic                   ready;
   logic                   pe_array_busy;
   logic [INST_AWIDTH-1:0] inst_addr;
   logic [ITER_WIDTH-1:0]  iter_cnt;
   logic                   done;
   logic [CWIDTH-1:0]      cycle_cnt;

   modport master (
      output start, abort, stall, inst_num, iter_num,
      input  ready, pe_array_busy, inst_addr, iter_cnt, done, cycle_cnt
   );

   modport slave (
      input  start, abort, stall, inst_num, iter_num,
      output ready, pe_array_busy, inst_addr, iter_cnt, done, cycle_cnt
   );
endinterface

// File: rtl/cgra_array_sched_tc_counter.sv
// Clearable up-counter with terminal-count compare; optionally wraps to 0 at terminal count.
module cgra_array_sched_tc_counter #(
   parameter int unsigned W    = 8,
   parameter bit          WRAP = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] tc_val,
   output logic [W-1:0] cnt,
   output logic         tc
);

   assign tc = (cnt == tc_val);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= (WRAP && tc) ? '0 : cnt + W'(1);
   end

endmodule

// File: rtl/cgra_array_sched.sv
// Run-time sequencer for the 2x2 torus PE array: issues Inst_Num x Iter_Num instruction
// addresses, drains the PE pipeline, then pulses done.
module cgra_array_sched
   import cgra_array_sched_pkg::*;
#(
   parameter int unsigned INST_AWIDTH  = INST_AWIDTH_DEF,
   parameter int unsigned ITER_WIDTH   = ITER_WIDTH_DEF,
   parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
   parameter int unsigned CWIDTH       = CWIDTH_DEF
) (
   input  logic               clk,
   input  logic               rst,
   cgra_array_sched_if.slave  bus
);

   localparam int unsigned DW = cnt_width(DRAIN_CYCLES);

   state_e                 state;
   state_e                 state_nx;
   logic [INST_AWIDTH:0]   inst_num_q;
   logic [ITER_WIDTH-1:0]  iter_num_q;
   logic [CWIDTH-1:0]      cycle_cnt_q;
   logic [INST_AWIDTH-1:0] addr_cnt;
   logic [ITER_WIDTH-1:0]  iter_cnt;
   logic [DW-1:0]          drain_cnt_unused;
   logic                   addr_tc;
   logic                   iter_tc;
   logic                   drain_tc;
   logic                   addr_wrap;
   logic                   last_issue;

   logic                   ready_c;
   logic                   issue_c;
   logic                   done_c;
   logic                   launch_c;
   logic                   cyc_en_c;
   logic                   drain_en_c;

   assign addr_wrap  = issue_c & addr_tc;
   assign last_issue = addr_wrap & iter_tc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   // Abort overrides every transition, including a launch in IDLE
   always_comb begin
      state_nx = state;
      if (bus.abort) begin
         state_nx = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (bus.start)
                         state_nx = (bus.inst_num == '0 || bus.iter_num == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (last_issue) state_nx = ST_DRAIN;
            ST_DRAIN: if (drain_tc)   state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
         endcase
      end
   end

   // Busy and done also react to abort within the same cycle
   always_comb begin
      ready_c    = 1'b0;
      issue_c    = 1'b0;
      done_c     = 1'b0;
      launch_c   = 1'b0;
      cyc_en_c   = 1'b0;
      drain_en_c = 1'b0;
      case (state)
         ST_IDLE: begin
            ready_c  = 1'b1;
            launch_c = bus.start & ~bus.abort;
         end
         ST_RUN: begin
            issue_c  = ~bus.stall & ~bus.abort;
            cyc_en_c = ~bus.abort;
         end
         ST_DRAIN: begin
            drain_en_c = 1'b1;
            cyc_en_c   = ~bus.abort;
         end
         ST_DONE:  done_c = ~bus.abort;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst_num_q <= '0;
         iter_num_q <= '0;
      end else if (launch_c) begin
         inst_num_q <= bus.inst_num;
         iter_num_q <= bus.iter_num;
      end
   end

   // Profiling counter saturates rather than wrapping
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cycle_cnt_q <= '0;
      else if (launch_c)
         cycle_cnt_q <= '0;
      else if (cyc_en_c && cycle_cnt_q != '1)
         cycle_cnt_q <= cycle_cnt_q + CWIDTH'(1);
   end

   cgra_array_sched_tc_counter #(.W(INST_AWIDTH), .WRAP(1'b1)) u_addr_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (launch_c),
      .en     (issue_c),
      .tc_val (INST_AWIDTH'(inst_num_q - (INST_AWIDTH+1)'(1))),
      .cnt    (addr_cnt),
      .tc     (addr_tc)
   );

   cgra_array_sched_tc_counter #(.W(ITER_WIDTH), .WRAP(1'b0)) u_iter_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (launch_c),
      .en     (addr_wrap),
      .tc_val (iter_num_q - ITER_WIDTH'(1)),
      .cnt    (iter_cnt),
      .tc     (iter_tc)
   );

   cgra_array_sched_tc_counter #(.W(DW), .WRAP(1'b1)) u_drain_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (~drain_en_c),
      .en     (drain_en_c),
      .tc_val (DW'(DRAIN_CYCLES - 1)),
      .cnt    (drain_cnt_unused),
      .tc     (drain_tc)
   );

   assign bus.ready         = ready_c;
   assign bus.pe_array_busy = issue_c;
   assign bus.done          = done_c;
   assign bus.inst_addr     = addr_cnt;
   assign bus.iter_cnt      = iter_cnt;
   assign bus.cycle_cnt     = cycle_cnt_q;

endmodule

// File: tb/tb_cgra_array_sched.sv
// Scoreboard bench for cgra_array_sched: expected issue addresses and completion records are
// queued at launch and retired against the DUT as busy/done appear.
module tb_cgra_array_sched;
   import cgra_array_sched_pkg::*;

   localparam int unsigned IAW   = INST_AWIDTH_DEF;
   localparam int unsigned ITW   = ITER_WIDTH_DEF;
   localparam int unsigned CW    = CWIDTH_DEF;
   localparam int unsigned DRAIN = DRAIN_CYCLES_DEF;

   typedef struct {
      int unsigned cyc;
      int unsigned iter;
      int unsigned ccnt;
   } done_rec_t;

   logic        clk = 1'b0;
   logic        rst;
   int unsigned cyc = 0;
   int          n_vec = 0;
   int          n_err = 0;

   int unsigned addr_q[$];
   done_rec_t   done_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cgra_array_sched_if #(.INST_AWIDTH(IAW), .ITER_WIDTH(ITW), .CWIDTH(CW)) bus ();

   cgra_array_sched #(
      .INST_AWIDTH (IAW),
      .ITER_WIDTH  (ITW),
      .DRAIN_CYCLES(DRAIN),
      .CWIDTH      (CW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Retire scoreboard entries whenever the DUT issues or completes
   always @(negedge clk) begin
      int unsigned exp_a;
      done_rec_t   r;
      if (!rst) begin
         if (bus.pe_array_busy) begin
            exp_a = (addr_q.size() != 0) ? addr_q.pop_front() : 32'hDEAD_BEEF;
            check("inst_addr", 64'(bus.inst_addr), 64'(exp_a));
            check("ready_in_run", 64'(bus.ready), 64'(0));
         end
         if (bus.done) begin
            if (done_q.size() == 0) begin
               check("done_unexpected", 64'(bus.done), 64'(0));
            end else begin
               r = done_q.pop_front();
               check("done_cycle", 64'(cyc), 64'(r.cyc));
               check("done_iter_cnt", 64'(bus.iter_cnt), 64'(r.iter));
               check("done_cycle_cnt", 64'(bus.cycle_cnt), 64'(r.ccnt));
            end
         end
      end
   end

   // Launch a kernel and run it to completion; stall is held for st_len cycles from offset st_off
   task automatic run_kernel(input int unsigned ni, input int unsigned nt,
                             input int unsigned st_off, input int unsigned st_len);
      int unsigned n, t0, done_off, ccnt, exp_iter;
      n = ni * nt;
      if (n == 0) begin
         done_off = 1; ccnt = 0; exp_iter = 0;
      end else begin
         done_off = 1 + n + st_len + DRAIN;
         ccnt     = n + st_len + DRAIN;
         exp_iter = nt;
      end
      for (int i = 0; i < int'(n); i++) addr_q.push_back(int'(i) % ni);
      t0 = cyc;
      done_q.push_back('{cyc: t0 + done_off, iter: exp_iter, ccnt: ccnt});
      bus.start    = 1'b1;
      bus.inst_num = (IAW+1)'(ni);
      bus.iter_num = ITW'(nt);
      tick();
      bus.start    = 1'b0;
      bus.inst_num = (IAW+1)'($urandom);
      bus.iter_num = ITW'($urandom);
      for (int unsigned k = 1; k <= done_off; k++) begin
         bus.stall = (k >= st_off) && (k < st_off + st_len);
         tick();
      end
      bus.stall = 1'b0;
      @(negedge clk);
      check("ready_after_done", 64'(bus.ready), 64'(1));
      check("inst_addr_hold", 64'(bus.inst_addr), 64'(0));
      check("iter_cnt_hold", 64'(bus.iter_cnt), 64'(exp_iter));
      check("cycle_cnt_hold", 64'(bus.cycle_cnt), 64'(ccnt));
      tick();
   endtask

   initial begin
      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.abort    = 1'b0;
      bus.stall    = 1'b0;
      bus.inst_num = '0;
      bus.iter_num = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_ready", 64'(bus.ready), 64'(1));
      check("rst_busy", 64'(bus.pe_array_busy), 64'(0));
      check("rst_inst_addr", 64'(bus.inst_addr), 64'(0));
      check("rst_iter_cnt", 64'(bus.iter_cnt), 64'(0));
      check("rst_done", 64'(bus.done), 64'(0));
      check("rst_cycle_cnt", 64'(bus.cycle_cnt), 64'(0));
      tick();

      run_kernel(4, 2, 0, 0);
      run_kernel(4, 2, 3, 3);
      run_kernel(0, 5, 0, 0);
      run_kernel(3, 0, 0, 0);
      run_kernel(1, 3, 0, 0);

      // Abort at addr 3 of iteration 1, with an ignored start pulse earlier in the run
      begin
         for (int i = 0; i < 7; i++) addr_q.push_back(int'(i) % 4);
         bus.start    = 1'b1;
         bus.inst_num = (IAW+1)'(4);
         bus.iter_num = ITW'(3);
         tick();
         bus.start = 1'b0;
         for (int k = 1; k <= 7; k++) begin
            bus.start    = (k == 3);
            bus.inst_num = (IAW+1)'(1);
            bus.iter_num = ITW'(1);
            tick();
         end
         bus.start = 1'b0;
         bus.abort = 1'b1;
         @(negedge clk);
         check("abort_busy_same_cycle", 64'(bus.pe_array_busy), 64'(0));
         tick();
         bus.abort = 1'b0;
         @(negedge clk);
         check("abort_ready", 64'(bus.ready), 64'(1));
         check("abort_inst_addr", 64'(bus.inst_addr), 64'(3));
         check("abort_iter_cnt", 64'(bus.iter_cnt), 64'(1));
         check("abort_cycle_cnt", 64'(bus.cycle_cnt), 64'(7));
         repeat (8) tick();
      end

      // Abort and start together in IDLE: no launch, counters untouched
      begin
         bus.start    = 1'b1;
         bus.abort    = 1'b1;
         bus.inst_num = (IAW+1)'(4);
         bus.iter_num = ITW'(1);
         tick();
         bus.start = 1'b0;
         bus.abort = 1'b0;
         @(negedge clk);
         check("abort_start_ready", 64'(bus.ready), 64'(1));
         check("abort_start_busy", 64'(bus.pe_array_busy), 64'(0));
         check("abort_start_cycle_cnt", 64'(bus.cycle_cnt), 64'(7));
         repeat (4) tick();
      end

      run_kernel(1024, 1, 0, 0);

      // Reset between edges in the middle of a run
      begin
         for (int i = 0; i < 16; i++) addr_q.push_back(int'(i) % 8);
         done_q.push_back('{cyc: cyc + 21, iter: 2, ccnt: 20});
         bus.start    = 1'b1;
         bus.inst_num = (IAW+1)'(8);
         bus.iter_num = ITW'(2);
         tick();
         bus.start = 1'b0;
         repeat (5) tick();
         #2 rst = 1'b1;
         #1;
         check("midrst_busy", 64'(bus.pe_array_busy), 64'(0));
         check("midrst_ready", 64'(bus.ready), 64'(1));
         check("midrst_inst_addr", 64'(bus.inst_addr), 64'(0));
         check("midrst_iter_cnt", 64'(bus.iter_cnt), 64'(0));
         check("midrst_cycle_cnt", 64'(bus.cycle_cnt), 64'(0));
         check("midrst_done", 64'(bus.done), 64'(0));
         addr_q.delete();
         done_q.delete();
         tick();
         rst = 1'b0;
         tick();
      end

      run_kernel(4, 2, 0, 0);

      check("addr_q_drained", 64'(addr_q.size()), 64'(0));
      check("done_q_drained", 64'(done_q.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
